vga_text_renderer: RTL

- Downstream consumer of the 720x400@70Hz VGA timing generator; renders an 80x25 text screen with 9x16 cells and 16-colour attributes.
- Fetches char/attr words from text RAM and glyph rows from font ROM through a fixed 4-stage pipeline.
- Outputs 24-bit RGB with hsync, vsync and display-enable, all delayed to stay aligned.

---
 rtl/vga_text_renderer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_text_renderer.sv
// 80x25 text-mode renderer: counts cell position from the timing generator's active
// strobes, fetches char/attr then glyph rows, and emits palette RGB 4 cycles after input.
module vga_text_renderer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int CHAR_W = 9,
    parameter int CHAR_H = 16
) (
    input  logic        clock,
    input  logic        rst_i,
    input  logic        hs_i,
    input  logic        vs_i,
    input  logic        h_active,
    input  logic        v_active,
    input  logic        eos,
    input  logic        cursor_en,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic [10:0] vram_addr,
    input  logic [15:0] vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o
);
    localparam int PXW = $clog2(CHAR_W);
    localparam int CW  = $clog2(COLS + 1);
    localparam int LW  = $clog2(CHAR_H);
    localparam int RW  = $clog2(ROWS + 1);

    logic de;
    assign de = h_active & v_active;

    // stage 0: position counters
    logic [PXW-1:0] px_q, px_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LW-1:0]  line_q, line_d;
    logic [RW-1:0]  row_q, row_d;
    logic           de_prev_q;
    logic [5:0]     frame_q;

    // stage 1..4 registers
    logic [10:0]    vram_addr_q, vram_addr_d;
    logic [PXW-1:0] s1_px_q, s2_px_q;
    logic [LW-1:0]  s1_line_q;
    logic           s1_cur_q, s1_cur_d, s1_off_q, s1_off_d;
    logic [11:0]    font_addr_q;
    logic [7:0]     s2_attr_q;
    logic           s2_ext_q, s2_cur_q, s2_off_q;
    logic           s3_pix_q, s3_pix_d, s3_off_q;
    logic [3:0]     s3_fg_q, s3_fg_d, s3_bg_q, s3_bg_d;
    logic [23:0]    rgb_q, rgb_d;
    logic [3:0][2:0] sync_q;  // {hs, vs, de} delay line

    always_comb begin
        px_d   = px_q;
        col_d  = col_q;
        line_d = line_q;
        row_d  = row_q;
        if (de) begin
            if (px_q == PXW'(CHAR_W - 1)) begin
                px_d = '0;
                if (col_q != CW'(COLS)) col_d = col_q + 1'b1;
            end else begin
                px_d = px_q + 1'b1;
            end
        end else begin
            px_d  = '0;
            col_d = '0;
        end
        // end-of-screen outranks a coincident end-of-line
        if (eos) begin
            line_d = '0;
            row_d  = '0;
        end else if (de_prev_q && !de) begin
            if (line_q == LW'(CHAR_H - 1)) begin
                line_d = '0;
                if (row_q != RW'(ROWS)) row_d = row_q + 1'b1;
            end else begin
                line_d = line_q + 1'b1;
            end
        end
    end

    always_comb begin
        vram_addr_d = 11'(row_q) * 11'(COLS) + 11'(col_q);
        s1_off_d    = (col_q == CW'(COLS)) || (row_q == RW'(ROWS));
        s1_cur_d    = cursor_en && (int'(col_q) == int'(cursor_col)) &&
                      (int'(row_q) == int'(cursor_row)) && (int'(line_q) >= CHAR_H - 2);
    end

    logic [7:0] glyph_sh;
    logic       glyph_bit;
    always_comb begin
        glyph_sh = font_data << s2_px_q;
        // the 9th column repeats bit 0 only for line-drawing characters 0xC0..0xDF
        if (int'(s2_px_q) >= 8) glyph_bit = s2_ext_q & font_data[0];
        else                    glyph_bit = glyph_sh[7];
        s3_pix_d = glyph_bit | (s2_cur_q & ~frame_q[4]);
        s3_bg_d  = {1'b0, s2_attr_q[6:4]};
        s3_fg_d  = (s2_attr_q[7] & frame_q[5]) ? s3_bg_d : s2_attr_q[3:0];
    end

    function automatic logic [7:0] comp(input logic inten, input logic on);
        if (on) return inten ? 8'hFF : 8'hAA;
        return inten ? 8'h55 : 8'h00;
    endfunction

    function automatic logic [23:0] pal(input logic [3:0] c);
        logic [7:0] gc;
        gc = (c == 4'h6) ? 8'h55 : comp(c[3], c[1]);
        return {comp(c[3], c[2]), gc, comp(c[3], c[0])};
    endfunction

    always_comb begin
        rgb_d = '0;
        if (sync_q[2][0] && !s3_off_q) rgb_d = pal(s3_pix_q ? s3_fg_q : s3_bg_q);
    end

    always_ff @(posedge clock or posedge rst_i) begin
        if (rst_i) begin
            px_q        <= '0;
            col_q       <= '0;
            line_q      <= '0;
            row_q       <= '0;
            de_prev_q   <= 1'b0;
            frame_q     <= '0;
            vram_addr_q <= '0;
            s1_px_q     <= '0;
            s1_line_q   <= '0;
            s1_cur_q    <= 1'b0;
            s1_off_q    <= 1'b0;
            font_addr_q <= '0;
            s2_px_q     <= '0;
            s2_attr_q   <= '0;
            s2_ext_q    <= 1'b0;
            s2_cur_q    <= 1'b0;
            s2_off_q    <= 1'b0;
            s3_pix_q    <= 1'b0;
            s3_fg_q     <= '0;
            s3_bg_q     <= '0;
            s3_off_q    <= 1'b0;
            rgb_q       <= '0;
            sync_q      <= '0;
        end else begin
            px_q        <= px_d;
            col_q       <= col_d;
            line_q      <= line_d;
            row_q       <= row_d;
            de_prev_q   <= de;
            frame_q     <= frame_q + {5'd0, eos};
            vram_addr_q <= vram_addr_d;
            s1_px_q     <= px_q;
            s1_line_q   <= line_q;
            s1_cur_q    <= s1_cur_d;
            s1_off_q    <= s1_off_d;
            font_addr_q <= {vram_data[7:0], 4'(s1_line_q)};
            s2_px_q     <= s1_px_q;
            s2_attr_q   <= vram_data[15:8];
            s2_ext_q    <= (vram_data[7:5] == 3'b110);
            s2_cur_q    <= s1_cur_q;
            s2_off_q    <= s1_off_q;
            s3_pix_q    <= s3_pix_d;
            s3_fg_q     <= s3_fg_d;
            s3_bg_q     <= s3_bg_d;
            s3_off_q    <= s2_off_q;
            rgb_q       <= rgb_d;
            sync_q      <= {sync_q[2:0], {hs_i, vs_i, de}};
        end
    end

    assign vram_addr = vram_addr_q;
    assign font_addr = font_addr_q;
    assign r    = rgb_q[23:16];
    assign g    = rgb_q[15:8];
    assign b    = rgb_q[7:0];
    assign hs_o = sync_q[3][2];
    assign vs_o = sync_q[3][1];
    assign de_o = sync_q[3][0];
endmodule
